// File: rtl/sinus_analyzer_pkg.sv
// Shared FSM states, default parameters and helpers for the sinus_analyzer monitor.
package sinus_analyzer_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int CNT_W_DEF      = 16;
  localparam int HYST_DEF       = 65536;
  localparam int MIN_PERIOD_DEF = 4;
  localparam int MAX_PERIOD_DEF = 1000;
  localparam int LOCK_CNT_DEF   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN_POS,
    S_RUN_NEG
  } state_t;

  // Two period lengths count as the same frequency when they differ by at most one sample.
  function automatic logic within_one(input int unsigned a, input int unsigned b);
    return (a > b) ? ((a - b) <= 1) : ((b - a) <= 1);
  endfunction

endpackage

// File: rtl/sinus_analyzer_zero_cross_det.sv
// Hysteresis comparator: flags non-negative samples (crossing) and samples below -HYST (armed).
module sinus_analyzer_zero_cross_det #(
  parameter int DATA_W = 24,
  parameter int HYST   = 65536
) (
  input  logic signed [DATA_W-1:0] i_sample,
  output logic                     o_crossing,
  output logic                     o_armed
);

  localparam logic signed [DATA_W-1:0] NEG_HYST = DATA_W'(-HYST);

  assign o_crossing = ~i_sample[DATA_W-1];
  assign o_armed    = (i_sample < NEG_HYST);

endmodule

// File: rtl/sinus_analyzer.sv
// Per-period length, peak and frequency-lock monitor for a signed sample stream.
// Optional dc_offset output is built when SINUS_ANALYZER_DC_EN is defined.
module sinus_analyzer
  import sinus_analyzer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int HYST       = HYST_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int MAX_PERIOD = MAX_PERIOD_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic        [CNT_W-1:0]  period,
  output logic signed [DATA_W-1:0] peak_max,
  output logic signed [DATA_W-1:0] peak_min,
  output logic signed [DATA_W:0]   peak_pp,
  output logic                     meas_valid,
  output logic                     locked,
  output logic                     timeout
`ifdef SINUS_ANALYZER_DC_EN
  ,
  output logic signed [DATA_W-1:0] dc_offset
`endif
);

  localparam int               MC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_CNT);

  state_t                   r_state;
  logic        [CNT_W-1:0]  r_cnt;
  logic        [CNT_W-1:0]  r_period;
  logic signed [DATA_W-1:0] r_max, r_min;
  logic signed [DATA_W-1:0] r_peak_max, r_peak_min;
  logic signed [DATA_W:0]   r_peak_pp;
  logic                     r_meas_valid, r_locked, r_timeout, r_prev_ok;
  logic        [MC_W-1:0]   r_match_cnt;

  logic                     w_crossing, w_armed;
  logic                     w_run, w_tmo, w_close, w_publish;
  logic        [MC_W-1:0]   w_match_next;
  logic signed [DATA_W:0]   w_pp;

  sinus_analyzer_zero_cross_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_zcd (
    .i_sample   (data_in),
    .o_crossing (w_crossing),
    .o_armed    (w_armed)
  );

  assign w_run     = (r_state == S_RUN_POS) || (r_state == S_RUN_NEG);
  assign w_tmo     = data_valid && w_run && (r_cnt == CNT_MAX);
  assign w_close   = data_valid && (r_state == S_RUN_NEG) && w_crossing && !w_tmo;
  assign w_publish = w_close && (r_cnt >= CNT_MIN);
  // Sign-extend both operands so max - min can never overflow.
  assign w_pp      = {r_max[DATA_W-1], r_max} - {r_min[DATA_W-1], r_min};

  always_comb begin
    w_match_next = '0;
    if (r_prev_ok && within_one(32'(r_cnt), 32'(r_period)))
      w_match_next = (r_match_cnt == MC_LOCK) ? r_match_cnt : r_match_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_max        <= '0;
      r_min        <= '0;
      r_period     <= '0;
      r_peak_max   <= '0;
      r_peak_min   <= '0;
      r_peak_pp    <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_prev_ok    <= 1'b0;
      r_match_cnt  <= '0;
    end else begin
      r_meas_valid <= w_publish;
      r_timeout    <= w_tmo;
      if (w_tmo) begin
        r_state     <= S_IDLE;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
        r_prev_ok   <= 1'b0;
      end else if (w_close) begin
        // NOTE: non-blocking updates let the publish read the pre-crossing max/min
        // while the same edge restarts them from the crossing sample.
        if (w_publish) begin
          r_period    <= r_cnt;
          r_peak_max  <= r_max;
          r_peak_min  <= r_min;
          r_peak_pp   <= w_pp;
          r_match_cnt <= w_match_next;
          r_locked    <= (w_match_next == MC_LOCK);
          r_prev_ok   <= 1'b1;
        end else begin
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
        end
        r_cnt   <= CNT_W'(1);
        r_max   <= data_in;
        r_min   <= data_in;
        r_state <= S_RUN_POS;
      end else if (data_valid) begin
        case (r_state)
          S_IDLE: if (w_armed) r_state <= S_ARM;
          S_ARM: begin
            if (w_crossing) begin
              r_cnt   <= CNT_W'(1);
              r_max   <= data_in;
              r_min   <= data_in;
              r_state <= S_RUN_POS;
            end
          end
          default: begin
            r_cnt <= r_cnt + 1'b1;
            if (data_in > r_max) r_max <= data_in;
            if (data_in < r_min) r_min <= data_in;
            if (w_armed) r_state <= S_RUN_NEG;
          end
        endcase
      end
    end
  end

  assign period     = r_period;
  assign peak_max   = r_peak_max;
  assign peak_min   = r_peak_min;
  assign peak_pp    = r_peak_pp;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

`ifdef SINUS_ANALYZER_DC_EN
  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W-1:0] r_dc;

  assign w_sum = {r_max[DATA_W-1], r_max} + {r_min[DATA_W-1], r_min};

  always_ff @(posedge clk) begin
    if (reset)          r_dc <= '0;
    else if (w_publish) r_dc <= DATA_W'(w_sum >>> 1);
  end

  assign dc_offset = r_dc;
`endif

endmodule

// File: tb/tb_sinus_analyzer.sv
// Randomized self-checking bench for sinus_analyzer against a sample-history reference model.
// Define SINUS_ANALYZER_DC_EN to also exercise dc_offset.
module tb_sinus_analyzer;

  localparam int  DATA_W     = 24;
  localparam int  CNT_W      = 16;
  localparam int  HYST       = 65536;
  localparam int  MIN_PERIOD = 4;
  localparam int  MAX_PERIOD = 1000;
  localparam int  LOCK_CNT   = 3;
  localparam real PI         = 3.14159265358979323846;

  logic                     clk        = 1'b0;
  logic                     reset      = 1'b1;
  logic signed [DATA_W-1:0] data_in    = '0;
  logic                     data_valid = 1'b0;
  logic        [CNT_W-1:0]  period;
  logic signed [DATA_W-1:0] peak_max, peak_min;
  logic signed [DATA_W:0]   peak_pp;
  logic                     meas_valid, locked, timeout;
`ifdef SINUS_ANALYZER_DC_EN
  logic signed [DATA_W-1:0] dc_offset;
`endif

  sinus_analyzer dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .period     (period),
    .peak_max   (peak_max),
    .peak_min   (peak_min),
    .peak_pp    (peak_pp),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
`ifdef SINUS_ANALYZER_DC_EN
    ,
    .dc_offset  (dc_offset)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples of the open period, measured afresh at each crossing.
  int     m_hist[$];
  bit     m_run, m_neg, m_prev_ok;
  int     m_prev, m_mcnt;
  longint e_period, e_max, e_min, e_dc;
  bit     e_mv, e_to, e_locked;

  bit     obs_mv, obs_to, obs_locked;
  int     n_to_seen;
  int     pub_locked[$];
  int     pub_period[$];

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_run = 0; m_neg = 0; m_prev_ok = 0; m_prev = 0; m_mcnt = 0;
    e_period = 0; e_max = 0; e_min = 0; e_dc = 0;
    e_mv = 0; e_to = 0; e_locked = 0;
  endtask

  task automatic model_step(input int x);
    e_mv = 0;
    e_to = 0;
    if (!m_run) begin
      if (!m_neg) m_neg = (x < -HYST);
      else if (x >= 0) begin
        m_run = 1; m_neg = 0;
        m_hist.delete(); m_hist.push_back(x);
      end
    end else if (m_hist.size() == MAX_PERIOD) begin
      e_to = 1; e_locked = 0; m_mcnt = 0; m_prev_ok = 0;
      m_run = 0; m_neg = 0; m_hist.delete();
    end else if (m_neg && x >= 0) begin
      if (m_hist.size() < MIN_PERIOD) begin
        m_mcnt = 0; e_locked = 0;
      end else begin
        int     len;
        longint mx, mn;
        len = m_hist.size();
        mx = m_hist[0];
        mn = m_hist[0];
        foreach (m_hist[i]) begin
          if (m_hist[i] > mx) mx = m_hist[i];
          if (m_hist[i] < mn) mn = m_hist[i];
        end
        e_mv = 1; e_period = len; e_max = mx; e_min = mn; e_dc = (mx + mn) >>> 1;
        if (m_prev_ok && (len - m_prev <= 1) && (m_prev - len <= 1))
          m_mcnt = (m_mcnt < LOCK_CNT) ? m_mcnt + 1 : LOCK_CNT;
        else
          m_mcnt = 0;
        e_locked = (m_mcnt == LOCK_CNT);
        m_prev = len; m_prev_ok = 1;
      end
      m_hist.delete(); m_hist.push_back(x);
      m_neg = 0;
    end else begin
      m_hist.push_back(x);
      if (x < -HYST) m_neg = 1;
    end
  endtask

  task automatic send(input int x);
    @(negedge clk);
    data_in    = DATA_W'(x);
    data_valid = 1'b1;
    model_step(x);
    @(negedge clk);
    data_valid = 1'b0;
    obs_mv     = meas_valid;
    obs_to     = timeout;
    obs_locked = locked;
    check("meas_valid", meas_valid, e_mv);
    check("timeout",    timeout,    e_to);
    check("locked",     locked,     e_locked);
    check("period",     period,     e_period);
    check("peak_max",   peak_max,   e_max);
    check("peak_min",   peak_min,   e_min);
    check("peak_pp",    peak_pp,    e_max - e_min);
`ifdef SINUS_ANALYZER_DC_EN
    check("dc_offset",  dc_offset,  e_dc);
`endif
    if (meas_valid) begin
      pub_locked.push_back(int'(locked));
      pub_period.push_back(int'(period));
    end
    if (timeout) n_to_seen++;
    @(negedge clk);
    check("mv_one_cycle", meas_valid, 0);
    check("to_one_cycle", timeout, 0);
    repeat ($urandom_range(2)) @(negedge clk);
  endtask

  function automatic int sine_at(int n, int len, int amp, int ofs);
    real r;
    r = real'(amp) * $sin(2.0 * PI * real'(n) / real'(len));
    return int'(r) + ofs;
  endfunction

  task automatic send_sine(input int len, input int periods, input int amp, input int ofs,
                           input int jit);
    for (int n = 0; n < len * periods; n++) begin
      int j;
      j = (jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0;
      send(sine_at(n % len, len, amp, ofs) + j);
    end
  endtask

  task automatic apply_reset(input bit with_valid);
    @(negedge clk);
    reset      = 1'b1;
    data_valid = with_valid;
    data_in    = DATA_W'(3000);
    @(negedge clk);
    data_valid = 1'b0;
    check("rst_period",     period,     0);
    check("rst_peak_max",   peak_max,   0);
    check("rst_peak_min",   peak_min,   0);
    check("rst_peak_pp",    peak_pp,    0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_locked",     locked,     0);
    check("rst_timeout",    timeout,    0);
`ifdef SINUS_ANALYZER_DC_EN
    check("rst_dc_offset",  dc_offset,  0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pub_locked.delete();
    pub_period.delete();
    n_to_seen = 0;
  endtask

  initial begin
    apply_reset(1'b0);

    // Reset in the middle of a negative half-period, with a crossing sample presented.
    send_sine(40, 3, 6000000, 0, 0);
    send(5000);
    repeat (7) send(200000);
    repeat (9) send(-200000);
    apply_reset(1'b1);
    send_sine(40, 3, 6000000, 0, 0);
    check("restart_pubs", pub_period.size(), 1);
    check("restart_period", period, 40);

    // Clean 40-sample tone: lock on the fourth measurement.
    apply_reset(1'b0);
    send_sine(40, 8, 6000000, 0, 0);
    check("tone_pubs", pub_period.size(), 6);
    if (pub_locked.size() >= 4) begin
      check("tone_lock_pub3", pub_locked[2], 0);
      check("tone_lock_pub4", pub_locked[3], 1);
    end
    check("tone_period",   period,   40);
    check("tone_peak_max", peak_max, 6000000);
    check("tone_peak_min", peak_min, -6000000);
    check("tone_peak_pp",  peak_pp,  12000000);

    // Tone stops at a constant positive level: timeout 1000 samples after the crossing.
    pub_period.delete();
    pub_locked.delete();
    send(100);
    for (int i = 1; i <= MAX_PERIOD; i++) begin
      send(100);
      if (i == MAX_PERIOD - 1) check("to_not_early", obs_to, 0);
      if (i == MAX_PERIOD)     check("to_at_1000",   obs_to, 1);
    end
    check("to_pubs",      pub_period.size(), 1);
    check("to_locked",    locked,   0);
    check("to_hold_per",  period,   40);
    check("to_hold_max",  peak_max, 6000000);
    check("to_hold_pp",   peak_pp,  12000000);

    // Small noise never arms the detector.
    apply_reset(1'b0);
    for (int i = 0; i < 300; i++) send(int'($urandom_range(2000)) - 1000);
    check("noise_pubs",     pub_period.size(), 0);
    check("noise_timeouts", n_to_seen, 0);

    // Frequency step 40 -> 38 samples: drop lock, relock on the third following publish.
    apply_reset(1'b0);
    send_sine(40, 6, 6000000, 0, 0);
    check("step_locked40", locked, 1);
    pub_period.delete();
    pub_locked.delete();
    send_sine(38, 6, 6000000, 0, 0);
    check("step_pubs", pub_period.size(), 6);
    if (pub_period.size() >= 5) begin
      check("step_last40",  pub_period[0], 40);
      check("step_first38", pub_period[1], 38);
      check("step_drop",    pub_locked[1], 0);
      check("step_not_yet", pub_locked[3], 0);
      check("step_relock",  pub_locked[4], 1);
    end

    // Short period closes as a glitch: no publish, lock lost.
    send(1000);
    send(-200000);
    send(1000);
    check("glitch_no_mv",  obs_mv, 0);
    check("glitch_locked", obs_locked, 0);

    // Random tones with offset and sample jitter.
    apply_reset(1'b0);
    for (int b = 0; b < 4; b++)
      send_sine(int'($urandom_range(60, 30)), 3, int'($urandom_range(8000000, 300000)),
                int'($urandom_range(40000)) - 20000, 100);

`ifdef SINUS_ANALYZER_DC_EN
    // Offset tone: dc_offset recovers the offset.
    apply_reset(1'b0);
    send_sine(40, 4, 6000000, 1000000, 0);
    check("dc_value",    dc_offset, 1000000);
    check("dc_peak_pp",  peak_pp,   12000000);
    check("dc_peak_max", peak_max,  7000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
